// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns 1/2/4-byte cache requests into byte
// RAM/I/O bus cycles, with I/O back-pressure, pause, flush and I/O write guard.
module mem_ctrl #(
  parameter int unsigned IO_GUARD = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        write_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned GW = (IO_GUARD < 1) ? 1 : $clog2(IO_GUARD + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    last_q, last_d;     // index of the final byte (0, 1 or 3)
  logic          wr_q, wr_d;
  logic [2:0]    idx_q, idx_d;       // read: next byte to issue; write: byte on the bus
  logic          pend_q, pend_d;     // a read byte issued last active cycle awaits capture
  logic          paused_q, paused_d;
  logic [31:0]   buf_q, buf_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [31:0]   resp_data_q, resp_data_d;

  logic [2:0]    issue_idx;
  logic [1:0]    cap_idx;
  logic [31:0]   wr_addr;
  logic          is_io;

  assign busy      = (state_q != IDLE) || (guard_q != '0);
  assign resp_data = resp_data_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_d      = last_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    paused_d    = !rdy_in;
    buf_d       = buf_q;
    resp_data_d = resp_data_q;
    guard_d     = guard_q;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    resp_valid  = 1'b0;
    write_done  = 1'b0;
    issue_idx   = idx_q;
    cap_idx     = idx_q[1:0] - 2'd1;
    wr_addr     = addr_q + {30'b0, idx_q[1:0]};
    is_io       = (wr_addr[17:16] == 2'b11);

    if (rdy_in && guard_q != '0) guard_d = guard_q - 1'b1;

    unique case (state_q)
      IDLE: begin
        // A flushed read is dropped at acceptance; a write is always taken.
        if (rdy_in && req_valid && guard_q == '0 && !(clear_in && !req_write)) begin
          addr_d  = req_addr;
          data_d  = req_data;
          wr_d    = req_write;
          idx_d   = '0;
          pend_d  = 1'b0;
          buf_d   = '0;
          unique case (req_size)
            2'd0:    last_d = 2'd0;
            2'd1:    last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
          state_d = req_write ? WRITE : READ;
        end
      end

      READ: begin
        if (rdy_in) begin
          if (clear_in) begin
            state_d = IDLE;
          end else if (pend_q && !paused_q) begin
            buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
            if (idx_q == {1'b0, last_q} + 3'd1) begin
              resp_data_d = buf_d;
              pend_d      = 1'b0;
              state_d     = DONE;
            end else begin
              mem_a = addr_q + {29'b0, idx_q};
              idx_d = idx_q + 3'd1;
            end
          end else begin
            // After a pause the RAM output is stale: reissue the first uncaptured byte.
            issue_idx = paused_q ? (idx_q - {2'b00, pend_q}) : idx_q;
            mem_a     = addr_q + {29'b0, issue_idx};
            idx_d     = issue_idx + 3'd1;
            pend_d    = 1'b1;
          end
        end
      end

      WRITE: begin
        mem_a    = wr_addr;
        mem_dout = data_q[{idx_q[1:0], 3'b000} +: 8];
        if (rdy_in && !(is_io && io_buffer_full)) begin
          mem_wr = 1'b1;
          if (is_io) guard_d = GW'(IO_GUARD);
          if (idx_q[1:0] == last_q) state_d = DONE;
          else                      idx_d   = idx_q + 3'd1;
        end
      end

      DONE: begin
        if (rdy_in) begin
          resp_valid = !wr_q;
          write_done = wr_q;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      paused_q    <= 1'b0;
      buf_q       <= '0;
      guard_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      paused_q    <= paused_d;
      buf_q       <= buf_d;
      guard_q     <= guard_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule
